// File: rtl/spi_txn_ctrl.sv
// -----------------------------------------------------------------------------
// spi_txn_ctrl
//   Transaction sequencer in front of an SPI byte engine. Accepts a command for
//   a burst of (i_cmd_len+1) bytes to one slave, latches mode/divisor for the
//   whole burst, drives the slave select with setup / hold / gap timing and
//   streams bytes between the host tx/rx handshakes and the engine (one engine
//   start per byte). The slave is never deselected mid-burst.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_cmd_*, o_cmd_ready    command: length-1, slave index, cpol, cpha, divisor
//   i_tx_* / o_tx_ready     tx byte stream into the burst
//   o_rx_* / i_rx_ready     rx byte stream out of the burst
//   o_busy                  sequencer not idle
//   o_txn_done              one-cycle pulse at end of burst
//   o_ss_n                  active-low slave selects (registered)
//   o_eng_*                 start, byte and latched mode/divisor to the engine
//   i_eng_*                 engine idle, byte-complete tick and received byte
// -----------------------------------------------------------------------------
module spi_txn_ctrl #(
   parameter int NUM_SS    = 4,
   parameter int LEN_W     = 4,
   parameter int SETUP_CYC = 2,
   parameter int HOLD_CYC  = 2,
   parameter int GAP_CYC   = 2,
   parameter int SS_W      = (NUM_SS > 2) ? $clog2(NUM_SS) : 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   // command
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [LEN_W-1:0]  i_cmd_len,
   input  logic [SS_W-1:0]   i_cmd_ss,
   input  logic              i_cmd_cpol,
   input  logic              i_cmd_cpha,
   input  logic [15:0]       i_cmd_dvsr,
   // tx stream
   input  logic              i_tx_valid,
   output logic              o_tx_ready,
   input  logic [7:0]        i_tx_data,
   // rx stream
   output logic              o_rx_valid,
   input  logic              i_rx_ready,
   output logic [7:0]        o_rx_data,
   // status
   output logic              o_busy,
   output logic              o_txn_done,
   output logic [NUM_SS-1:0] o_ss_n,
   // byte engine
   output logic              o_eng_start,
   output logic [7:0]        o_eng_din,
   output logic              o_eng_cpol,
   output logic              o_eng_cpha,
   output logic [15:0]       o_eng_dvsr,
   input  logic              i_eng_ready,
   input  logic              i_eng_done_tick,
   input  logic [7:0]        i_eng_dout
);

   localparam int TMR_MAX_A = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
   localparam int TMR_MAX   = (TMR_MAX_A > GAP_CYC) ? TMR_MAX_A : GAP_CYC;
   localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(SETUP_CYC - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYC - 1);
   localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYC - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_CFG, S_SETUP, S_FETCH, S_START,
      S_XFER, S_PUSH, S_HOLD, S_GAP, S_DONE
   } state_t;

   state_t              r_state, w_next;
   logic [TMR_W-1:0]    r_tmr;
   logic [LEN_W-1:0]    r_remaining;
   logic [SS_W-1:0]     r_ss;
   logic [NUM_SS-1:0]   r_ss_n;
   logic [7:0]          r_eng_din;
   logic [7:0]          r_rx_data;
   logic                r_eng_cpol;
   logic                r_eng_cpha;
   logic [15:0]         r_eng_dvsr;
   logic [NUM_SS-1:0]   w_sel;
   logic                w_ss_active;

   // ---------------------------------------------------------------- next state
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_cmd_valid)            w_next = S_CFG;
         S_CFG:                               w_next = S_SETUP;
         S_SETUP: if (r_tmr == SETUP_LAST)    w_next = S_FETCH;
         S_FETCH: if (i_tx_valid)             w_next = S_START;
         S_START: if (i_eng_ready)            w_next = S_XFER;
         S_XFER:  if (i_eng_done_tick)        w_next = S_PUSH;
         S_PUSH:  if (i_rx_ready)             w_next = (r_remaining == '0) ? S_HOLD : S_FETCH;
         S_HOLD:  if (r_tmr == HOLD_LAST)     w_next = S_GAP;
         S_GAP:   if (r_tmr == GAP_LAST)      w_next = S_DONE;
         S_DONE:                              w_next = S_IDLE;
         default:                             w_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------ state register
   always_ff @(posedge i_clk or posedge i_reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      if (i_reset) begin
         r_state <= S_IDLE;
         r_tmr   <= '0;
      end else begin
         r_state <= w_next;
         // Phase timer restarts on every state change; only the timed states read it.
         if (w_next != r_state) r_tmr <= '0;
         else if (r_state == S_SETUP || r_state == S_HOLD || r_state == S_GAP)
            r_tmr <= r_tmr + 1'b1;
      end
   end

   // ------------------------------------------------------ slave-select decode
   // An index with no matching line selects nothing; the burst still runs.
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NUM_SS; i++) w_sel[i] = (r_ss == SS_W'(i));
   end

   // Select is driven from the next state so o_ss_n is a clean register that
   // drops exactly on entry to SETUP and rises exactly on entry to GAP.
   always_comb begin
      w_ss_active = 1'b0;
      case (w_next)
         S_SETUP, S_FETCH, S_START, S_XFER, S_PUSH, S_HOLD: w_ss_active = 1'b1;
         default:                                           w_ss_active = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_remaining <= '0;
         r_ss        <= '0;
         r_ss_n      <= '1;
         r_eng_din   <= '0;
         r_rx_data   <= '0;
         r_eng_cpol  <= 1'b0;
         r_eng_cpha  <= 1'b0;
         r_eng_dvsr  <= '0;
      end else begin
         // Mode and divisor move only at accept; the CFG cycle that follows
         // lets the engine's idle sclk settle before select asserts.
         if (r_state == S_IDLE && i_cmd_valid) begin
            r_remaining <= i_cmd_len;
            r_ss        <= i_cmd_ss;
            r_eng_cpol  <= i_cmd_cpol;
            r_eng_cpha  <= i_cmd_cpha;
            r_eng_dvsr  <= i_cmd_dvsr;
         end
         if (r_state == S_FETCH && i_tx_valid)      r_eng_din <= i_tx_data;
         if (r_state == S_XFER && i_eng_done_tick)  r_rx_data <= i_eng_dout;
         if (r_state == S_PUSH && i_rx_ready && r_remaining != '0)
            r_remaining <= r_remaining - 1'b1;
         r_ss_n <= w_ss_active ? ~w_sel : '1;
      end
   end

   // ----------------------------------------------------------------- outputs
   assign o_cmd_ready = (r_state == S_IDLE);
   assign o_tx_ready  = (r_state == S_FETCH);
   assign o_rx_valid  = (r_state == S_PUSH);
   assign o_eng_start = (r_state == S_START);
   assign o_txn_done  = (r_state == S_DONE);
   assign o_busy      = (r_state != S_IDLE);
   assign o_ss_n      = r_ss_n;
   assign o_eng_din   = r_eng_din;
   assign o_rx_data   = r_rx_data;
   assign o_eng_cpol  = r_eng_cpol;
   assign o_eng_cpha  = r_eng_cpha;
   assign o_eng_dvsr  = r_eng_dvsr;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_txn_ctrl
//   Directed bench for spi_txn_ctrl with a behavioural loopback byte engine
//   (received byte = transmitted byte, fixed byte time). NUM_SS=4, SS_W=3 so
//   an out-of-range slave index can be driven.
// -----------------------------------------------------------------------------
module tb_spi_txn_ctrl;

   localparam int NUM_SS = 4;
   localparam int LEN_W  = 4;
   localparam int SS_W   = 3;
   localparam int ENG_BT = 2;   // engine model: done tick ENG_BT+1 cycles after start

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [LEN_W-1:0]  cmd_len;
   logic [SS_W-1:0]   cmd_ss;
   logic              cmd_cpol, cmd_cpha;
   logic [15:0]       cmd_dvsr;
   logic              tx_valid, tx_ready;
   logic [7:0]        tx_data;
   logic              rx_valid, rx_ready;
   logic [7:0]        rx_data;
   logic              busy, txn_done;
   logic [NUM_SS-1:0] ss_n;
   logic              eng_start;
   logic [7:0]        eng_din;
   logic              eng_cpol, eng_cpha;
   logic [15:0]       eng_dvsr;
   logic              eng_ready, eng_done_tick;
   logic [7:0]        eng_dout;

   always #5 clk = ~clk;

   spi_txn_ctrl #(
      .NUM_SS(NUM_SS), .LEN_W(LEN_W), .SETUP_CYC(2), .HOLD_CYC(2), .GAP_CYC(2), .SS_W(SS_W)
   ) dut (
      .i_clk(clk), .i_reset(reset),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_len(cmd_len),
      .i_cmd_ss(cmd_ss), .i_cmd_cpol(cmd_cpol), .i_cmd_cpha(cmd_cpha), .i_cmd_dvsr(cmd_dvsr),
      .i_tx_valid(tx_valid), .o_tx_ready(tx_ready), .i_tx_data(tx_data),
      .o_rx_valid(rx_valid), .i_rx_ready(rx_ready), .o_rx_data(rx_data),
      .o_busy(busy), .o_txn_done(txn_done), .o_ss_n(ss_n),
      .o_eng_start(eng_start), .o_eng_din(eng_din), .o_eng_cpol(eng_cpol),
      .o_eng_cpha(eng_cpha), .o_eng_dvsr(eng_dvsr),
      .i_eng_ready(eng_ready), .i_eng_done_tick(eng_done_tick), .i_eng_dout(eng_dout)
   );

   // ------------------------------------------------ loopback byte engine model
   logic       m_busy, m_sclk;
   logic [7:0] m_data;
   int         m_cnt;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         eng_ready     <= 1'b1;
         eng_done_tick <= 1'b0;
         eng_dout      <= '0;
         m_busy        <= 1'b0;
         m_sclk        <= 1'b0;
         m_data        <= '0;
         m_cnt         <= 0;
      end else begin
         eng_done_tick <= 1'b0;
         if (!m_busy) m_sclk <= eng_cpol;
         else         m_sclk <= ~m_sclk;
         if (!m_busy && eng_start) begin
            m_busy    <= 1'b1;
            eng_ready <= 1'b0;
            m_cnt     <= ENG_BT;
            m_data    <= eng_din;
         end else if (m_busy) begin
            if (m_cnt == 1) begin
               m_busy        <= 1'b0;
               eng_ready     <= 1'b1;
               eng_done_tick <= 1'b1;
               eng_dout      <= m_data;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   // ----------------------------------------------------------------- monitor
   logic       mon_clr;
   int         cyc, ss_low_cnt, rise_cnt, start_cnt, done_cnt, t_rise, t_done, ss_glitch;
   logic [3:0] ss_low_val;
   logic       prev_low;
   logic [7:0] rxq[$];

   initial cyc = 0;
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mon_clr) begin
         ss_low_cnt = 0; rise_cnt = 0; start_cnt = 0; done_cnt = 0;
         t_rise = 0; t_done = 0; ss_glitch = 0; ss_low_val = '1; prev_low = 1'b0;
         rxq.delete();
      end else begin
         if (ss_n != '1) begin
            if (!prev_low) ss_low_val = ss_n;
            else if (ss_n != ss_low_val) ss_glitch++;
            ss_low_cnt++;
         end else if (prev_low) begin
            rise_cnt++;
            t_rise = cyc;
         end
         prev_low = (ss_n != '1);
         if (eng_start) start_cnt++;
         if (txn_done) begin done_cnt++; t_done = cyc; end
         if (rx_valid && rx_ready) rxq.push_back(rx_data);
      end
   end

   // -------------------------------------------------------------- checking
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] rx_at(input int i);
      if (i < rxq.size()) return 32'(rxq[i]);
      return 32'hFFFF_FFFF;
   endfunction

   task automatic clear_mon();
      @(posedge clk); #1 mon_clr = 1'b1;
      @(negedge clk); #1 mon_clr = 1'b0;
   endtask

   task automatic issue_cmd(input logic [LEN_W-1:0] len, input logic [SS_W-1:0] ss,
                            input logic cpol, input logic cpha, input logic [15:0] dvsr);
      int n = 0;
      @(negedge clk);
      cmd_len = len; cmd_ss = ss; cmd_cpol = cpol; cmd_cpha = cpha; cmd_dvsr = dvsr;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) check("cmd_accept_timeout", 0, 1);
      @(posedge clk); #1 cmd_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input int delay);
      int n = 0;
      repeat (delay) @(negedge clk);
      @(negedge clk);
      tx_data = d; tx_valid = 1'b1;
      while (!tx_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) check("tx_handshake_timeout", 0, 1);
      @(posedge clk); #1 tx_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!txn_done && n < 500) begin @(negedge clk); n++; end
      check(tag, 32'(txn_done), 1);
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int         stall_bad, starts0;
   logic [7:0] held;

   initial begin
      reset = 1'b1; mon_clr = 1'b0;
      cmd_valid = 1'b0; cmd_len = '0; cmd_ss = '0; cmd_cpol = 1'b0; cmd_cpha = 1'b0; cmd_dvsr = '0;
      tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ss_n",      32'(ss_n), 32'hF);
      check("rst_busy",      32'(busy), 0);
      check("rst_eng_start", 32'(eng_start), 0);
      check("rst_rx_valid",  32'(rx_valid), 0);
      check("rst_txn_done",  32'(txn_done), 0);
      check("rst_eng_din",   32'(eng_din), 0);
      check("rst_rx_data",   32'(rx_data), 0);
      check("rst_eng_dvsr",  32'(eng_dvsr), 0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 1);

      // 1: single byte, slave 2, mode 0
      clear_mon();
      issue_cmd(4'd0, 3'd2, 1'b0, 1'b0, 16'd1);
      @(negedge clk);
      check("t1_cfg_ss_high", 32'(ss_n), 32'hF);
      check("t1_eng_dvsr",    32'(eng_dvsr), 1);
      send_byte(8'hA5, 0);
      wait_done("t1_done_seen");
      check("t1_rx_byte",   rx_at(0), 32'hA5);
      check("t1_rx_count",  32'(rxq.size()), 1);
      check("t1_ss_val",    32'(ss_low_val), 32'hB);
      // SETUP 2 + FETCH 1 + START 1 + XFER (ENG_BT+1)=3 + PUSH 1 + HOLD 2
      check("t1_ss_low_cyc", 32'(ss_low_cnt), 10);
      check("t1_starts",    32'(start_cnt), 1);
      check("t1_done_cnt",  32'(done_cnt), 1);
      check("t1_gap_to_done", 32'(t_done - t_rise), 2);
      check("t1_eng_din",   32'(eng_din), 32'hA5);

      // 2: four-byte burst, tx stalled 5 cycles before byte 3
      clear_mon();
      issue_cmd(4'd3, 3'd1, 1'b0, 1'b0, 16'd1);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h03, 5);
      send_byte(8'h04, 0);
      wait_done("t2_done_seen");
      check("t2_starts",   32'(start_cnt), 4);
      check("t2_ss_rises", 32'(rise_cnt), 1);
      check("t2_ss_glitch", 32'(ss_glitch), 0);
      check("t2_ss_val",   32'(ss_low_val), 32'hD);
      for (int i = 0; i < 4; i++) check($sformatf("t2_rx%0d", i), rx_at(i), 32'(i + 1));

      // 3: rx backpressure on byte 1 of a two-byte burst
      clear_mon();
      rx_ready = 1'b0;
      issue_cmd(4'd1, 3'd0, 1'b0, 1'b0, 16'd1);
      send_byte(8'h11, 0);
      begin
         int n = 0;
         while (!rx_valid && n < 200) begin @(negedge clk); n++; end
      end
      check("t3_rx_valid_up", 32'(rx_valid), 1);
      held = rx_data; starts0 = start_cnt; stall_bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!rx_valid || rx_data !== held || ss_n == '1) stall_bad++;
      end
      check("t3_stall_stable", 32'(stall_bad), 0);
      check("t3_no_start",     32'(start_cnt - starts0), 0);
      check("t3_held_data",    32'(held), 32'h11);
      rx_ready = 1'b1;
      send_byte(8'h22, 0);
      wait_done("t3_done_seen");
      check("t3_rx0",      rx_at(0), 32'h11);
      check("t3_rx1",      rx_at(1), 32'h22);
      check("t3_starts",   32'(start_cnt), 2);
      check("t3_ss_rises", 32'(rise_cnt), 1);

      // 4: mode change to cpol=1, cpha=1, dvsr=3
      check("t4_prev_cpol", 32'(eng_cpol), 0);
      clear_mon();
      issue_cmd(4'd0, 3'd3, 1'b1, 1'b1, 16'd3);
      @(negedge clk);
      check("t4_cpol",     32'(eng_cpol), 1);
      check("t4_cpha",     32'(eng_cpha), 1);
      check("t4_dvsr",     32'(eng_dvsr), 3);
      check("t4_cfg_ss",   32'(ss_n), 32'hF);
      @(negedge clk);
      check("t4_setup_ss", 32'(ss_n), 32'h7);
      check("t4_sclk_idle_high", 32'(m_sclk), 1);
      send_byte(8'h3C, 0);
      wait_done("t4_done_seen");
      check("t4_rx",         rx_at(0), 32'h3C);
      check("t4_dvsr_after", 32'(eng_dvsr), 3);

      // 5: out-of-range slave index
      clear_mon();
      issue_cmd(4'd0, 3'd5, 1'b0, 1'b0, 16'd1);
      send_byte(8'h5A, 0);
      wait_done("t5_done_seen");
      check("t5_ss_never_low", 32'(ss_low_cnt), 0);
      check("t5_rx",       rx_at(0), 32'h5A);
      check("t5_starts",   32'(start_cnt), 1);
      check("t5_done_cnt", 32'(done_cnt), 1);

      // 6: reset in XFER of byte 2, then a normal one-byte burst
      clear_mon();
      issue_cmd(4'd1, 3'd0, 1'b0, 1'b0, 16'd1);
      send_byte(8'h77, 0);
      send_byte(8'h88, 0);
      @(negedge clk);   // START
      @(negedge clk);   // XFER
      check("t6_in_xfer_ss", 32'(ss_n), 32'hE);
      reset = 1'b1;
      #1;
      check("t6_rst_ss_n",     32'(ss_n), 32'hF);
      check("t6_rst_rx_valid", 32'(rx_valid), 0);
      check("t6_rst_busy",     32'(busy), 0);
      check("t6_rst_dvsr",     32'(eng_dvsr), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("t6_cmd_ready", 32'(cmd_ready), 1);
      clear_mon();
      issue_cmd(4'd0, 3'd1, 1'b0, 1'b0, 16'd1);
      send_byte(8'h99, 0);
      wait_done("t6_done_seen");
      check("t6_rx",       rx_at(0), 32'h99);
      check("t6_done_cnt", 32'(done_cnt), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
